mem_arbiter: RTL

//   Arbitrates the single-port 8-bit memory between the instruction-fetch port (IF, read-only)
//   and the load/store port (LS, read/write). It sequences each granted access onto the memory

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Core-side request/response ports plus the single memory port
// of the IF/LS memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_req_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_input_data;
  logic [DATA_W-1:0] mem_output_data;
  logic              busy;

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_req_we,
    output ls_addr, ls_wdata,
    output mem_output_data,
    input  if_req_ready, if_rsp_valid,
    input  if_rsp_data,
    input  ls_req_ready, ls_rsp_valid,
    input  ls_rsp_data,
    input  mem_write, mem_address,
    input  mem_input_data, busy
  );

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_req_we,
    input  ls_addr, ls_wdata,
    input  mem_output_data,
    output if_req_ready, if_rsp_valid,
    output if_rsp_data,
    output ls_req_ready, ls_rsp_valid,
    output ls_rsp_data,
    output mem_write, mem_address,
    output mem_input_data, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch
// and load/store, one access in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int CNT_W = $clog2(RD_LAT + 2);

  state_t            state;
  logic              owner_ls;
  logic              we_q;
  logic              last_ls;
  logic [CNT_W-1:0]  cnt;
  logic              mw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic              if_rv_q;
  logic              ls_rv_q;
  logic [DATA_W-1:0] if_rd_q;
  logic [DATA_W-1:0] ls_rd_q;

  logic tie_ls;
  logic grant_ls;
  logic grant_if;
  logic idle;
  logic last_acc;

  // On a tie LS wins unless it was the last port served (RR)
  assign tie_ls   = (ARB_MODE != 0) || !last_ls;
  assign grant_ls = bus.ls_req_valid &&
                    (!bus.if_req_valid || tie_ls);
  assign grant_if = bus.if_req_valid && !grant_ls;
  assign idle     = (state == IDLE);
  assign last_acc = we_q || (cnt == CNT_W'(RD_LAT));

  assign bus.if_req_ready   = rst_n && idle && grant_if;
  assign bus.ls_req_ready   = rst_n && idle && grant_ls;
  assign bus.if_rsp_valid   = if_rv_q;
  assign bus.if_rsp_data    = if_rd_q;
  assign bus.ls_rsp_valid   = ls_rv_q;
  assign bus.ls_rsp_data    = ls_rd_q;
  assign bus.mem_write      = mw_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_input_data = wd_q;
  assign bus.busy           = !idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner_ls <= 1'b0;
      we_q     <= 1'b0;
      last_ls  <= 1'b0;
      cnt      <= '0;
      mw_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      if_rv_q  <= 1'b0;
      ls_rv_q  <= 1'b0;
      if_rd_q  <= '0;
      ls_rd_q  <= '0;
    end else begin
      mw_q    <= 1'b0;
      if_rv_q <= 1'b0;
      ls_rv_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_ls || grant_if) begin
            owner_ls <= grant_ls;
            last_ls  <= grant_ls;
            we_q     <= grant_ls && bus.ls_req_we;
            mw_q     <= grant_ls && bus.ls_req_we;
            addr_q   <= grant_ls ? bus.ls_addr
                                 : bus.if_addr;
            if (grant_ls) wd_q <= bus.ls_wdata;
            cnt      <= '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (last_acc) begin
            state <= RESP;
            if (owner_ls) begin
              ls_rv_q <= 1'b1;
              ls_rd_q <= we_q ? '0 : bus.mem_output_data;
            end else begin
              if_rv_q <= 1'b1;
              if_rd_q <= bus.mem_output_data;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
